// File: rtl/ram_pkg.sv
// Shared definitions for the true dual-port synchronous RAM:
// read-during-write mode encodings, clear sequencer state type and
// small constant helper functions.
package ram_pkg;

    localparam int RAM_READ_FIRST  = 0;
    localparam int RAM_WRITE_FIRST = 1;
    localparam int RAM_NO_CHANGE   = 2;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Ceiling log2, for sizing counters from a depth
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Even parity bit: makes the total number of ones in {bit, v} even
    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, issuing a write
// of zero per cycle, and holds busy high until the last word is written.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  CLR_CLEAR | zeroing word [cnt_q]; busy=1, user accesses are ignored
//  CLR_IDLE  | clear finished (or disabled); busy=0 forever after
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      busy,
    output logic                      clr_we,
    output logic [clog2(DEPTH)-1:0]   clr_addr
);

    localparam int CNT_W = clog2(DEPTH);

    clr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State and address counter registers; reset restarts the sweep at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            CLR_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/true_dual_port_ram_sync.sv
// Single-clock true dual-port RAM with inferred storage.
// Read-during-write behaviour is chosen by FIRST ("READ", "WRITE",
// "NOCHANGE"); OUTREG adds a second output register stage.
// Optional feature macro RAM_PARITY_EN: stores an even parity bit per word
// and adds perr1/perr2 outputs aligned with valid1/valid2.
// When both ports write the same address in one cycle, port 1 wins.
module true_dual_port_ram_sync
    import ram_pkg::*;
#(
    parameter int    DATA_WIDTH     = 8,
    parameter int    ADDR_WIDTH     = 10,
    parameter string FIRST          = "WRITE",
    parameter int    OUTREG         = 0,
    parameter int    CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable1,
    input  logic                  write1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] idata1,
    output logic [DATA_WIDTH-1:0] odata1,
    output logic                  valid1,
    input  logic                  enable2,
    input  logic                  write2,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] idata2,
    output logic [DATA_WIDTH-1:0] odata2,
    output logic                  valid2,
`ifdef RAM_PARITY_EN
    output logic                  perr1,
    output logic                  perr2,
`endif
    output logic                  busy,
    output logic                  collision
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int FIRST_MODE = (FIRST == "READ")     ? RAM_READ_FIRST :
                                (FIRST == "NOCHANGE") ? RAM_NO_CHANGE  :
                                                        RAM_WRITE_FIRST;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    logic [WORD_W-1:0]     mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  acc1, acc2, wr1, wr2, same_addr;
    logic                  mem_we1;
    logic [ADDR_WIDTH-1:0] mem_addr1;
    logic [WORD_W-1:0]     mem_wd1;
    logic [WORD_W-1:0]     wword1, wword2, old1, old2;
    logic                  coll_d, coll_q;

    logic                  ld1, ld2, val1_d, val2_d;
    logic [WORD_W-1:0]     nxt1, nxt2;
    logic [WORD_W-1:0]     rword1_q, rword2_q;
    logic                  rvalid1_q, rvalid2_q;
    logic [WORD_W-1:0]     out_word1, out_word2;
    logic                  out_valid1, out_valid2;

    ram_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

`ifdef RAM_PARITY_EN
    assign wword1 = {parity(64'(idata1)), idata1};
    assign wword2 = {parity(64'(idata2)), idata2};
`else
    assign wword1 = idata1;
    assign wword2 = idata2;
`endif

    // Access acceptance, clear-sequencer takeover of port 1, collision detect
    always_comb begin
        acc1      = enable1 & ~busy;
        acc2      = enable2 & ~busy;
        wr1       = acc1 & write1;
        wr2       = acc2 & write2;
        same_addr = (addr1 == addr2);
        mem_we1   = busy ? clr_we   : wr1;
        mem_addr1 = busy ? clr_addr : addr1;
        mem_wd1   = busy ? '0       : wword1;
        old1      = mem[addr1];
        old2      = mem[addr2];
        coll_d    = acc1 & acc2 & same_addr & (write1 | write2);
    end

    // Storage; port 1 is written last so it wins a same-address double write
    always_ff @(posedge clock) begin
        if (wr2) begin
            mem[addr2] <= wword2;
        end
        if (mem_we1) begin
            mem[mem_addr1] <= mem_wd1;
        end
    end

    generate
        if (FIRST_MODE == RAM_READ_FIRST) begin : g_read_first
            // Every accepted access returns the word as it stood before the edge
            always_comb begin
                ld1    = acc1;
                ld2    = acc2;
                nxt1   = old1;
                nxt2   = old2;
                val1_d = acc1;
                val2_d = acc2;
            end
        end else if (FIRST_MODE == RAM_NO_CHANGE) begin : g_no_change
            // Writes leave the output untouched; reads see the old word
            always_comb begin
                ld1    = acc1 & ~write1;
                ld2    = acc2 & ~write2;
                nxt1   = old1;
                nxt2   = old2;
                val1_d = acc1 & ~write1;
                val2_d = acc2 & ~write2;
            end
        end else begin : g_write_first
            // Writers echo their own data; a same-address reader sees the writer's data
            always_comb begin
                ld1    = acc1;
                ld2    = acc2;
                nxt1   = old1;
                nxt2   = old2;
                if (wr1) begin
                    nxt1 = wword1;
                end else if (wr2 && same_addr) begin
                    nxt1 = wword2;
                end
                if (wr2) begin
                    nxt2 = wword2;
                end else if (wr1 && same_addr) begin
                    nxt2 = wword1;
                end
                val1_d = acc1;
                val2_d = acc2;
            end
        end
    endgenerate

    // First read stage; data holds its last value when no access loads it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rword1_q  <= '0;
            rword2_q  <= '0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            rvalid1_q <= val1_d;
            rvalid2_q <= val2_d;
            coll_q    <= coll_d;
            if (ld1) begin
                rword1_q <= nxt1;
            end
            if (ld2) begin
                rword2_q <= nxt2;
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [WORD_W-1:0] oword1_q, oword2_q;
            logic              ovalid1_q, ovalid2_q;

            // Optional second output stage, a straight copy of the first
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    oword1_q  <= '0;
                    oword2_q  <= '0;
                    ovalid1_q <= 1'b0;
                    ovalid2_q <= 1'b0;
                end else begin
                    oword1_q  <= rword1_q;
                    oword2_q  <= rword2_q;
                    ovalid1_q <= rvalid1_q;
                    ovalid2_q <= rvalid2_q;
                end
            end

            assign out_word1  = oword1_q;
            assign out_word2  = oword2_q;
            assign out_valid1 = ovalid1_q;
            assign out_valid2 = ovalid2_q;
        end else begin : g_no_outreg
            assign out_word1  = rword1_q;
            assign out_word2  = rword2_q;
            assign out_valid1 = rvalid1_q;
            assign out_valid2 = rvalid2_q;
        end
    endgenerate

    assign odata1    = out_word1[DATA_WIDTH-1:0];
    assign odata2    = out_word2[DATA_WIDTH-1:0];
    assign valid1    = out_valid1;
    assign valid2    = out_valid2;
    assign collision = coll_q;

`ifdef RAM_PARITY_EN
    // A stored word with odd total ones has been corrupted
    assign perr1 = out_valid1 & (^out_word1);
    assign perr2 = out_valid2 & (^out_word2);
`endif

endmodule

// File: tb/tb_true_dual_port_ram_sync.sv
// Bench for true_dual_port_ram_sync: three instances (WRITE/OUTREG=0,
// READ/OUTREG=1, NOCHANGE/OUTREG=0) share one stimulus stream and are
// compared every cycle against a behavioural model.
module tb_true_dual_port_ram_sync;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NI    = 3;
    localparam int M_READ  = 0;
    localparam int M_WRITE = 1;
    localparam int M_NOCH  = 2;
    localparam int MODE [NI] = '{M_WRITE, M_READ, M_NOCH};
    localparam int LAT  [NI] = '{1, 2, 1};

    typedef struct packed {
        logic          v;
        logic          pe;
        logic [DW-1:0] d;
    } res_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable1, write1, enable2, write2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] idata1, idata2;
    logic [DW-1:0] odata [2*NI];
    logic          valid [2*NI];
    logic          busy  [NI];
    logic          coll  [NI];
`ifdef RAM_PARITY_EN
    logic          perr  [2*NI];
`endif

    int            n_checks = 0;
    int            n_errors = 0;

    logic [DW-1:0] mem_m [DEPTH];
    bit            bad_m [DEPTH];
    int            clear_left;
    res_t          pipe  [2*NI][$];
    logic [DW-1:0] last_d [2*NI];
    bit            exp_coll;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam string FM = (gi == 0) ? "WRITE" : (gi == 1) ? "READ" : "NOCHANGE";
        localparam int    OR = (gi == 1) ? 1 : 0;
        true_dual_port_ram_sync #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST(FM), .OUTREG(OR), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clock(clock), .reset(reset),
            .enable1(enable1), .write1(write1), .addr1(addr1), .idata1(idata1),
            .odata1(odata[2*gi]), .valid1(valid[2*gi]),
            .enable2(enable2), .write2(write2), .addr2(addr2), .idata2(idata2),
            .odata2(odata[2*gi+1]), .valid2(valid[2*gi+1]),
`ifdef RAM_PARITY_EN
            .perr1(perr[2*gi]), .perr2(perr[2*gi+1]),
`endif
            .busy(busy[gi]), .collision(coll[gi])
        );
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected result of one port's access under a given read-during-write mode
    function automatic res_t predict(input int mode, input bit acc, input bit wr,
                                     input logic [DW-1:0] wd, input logic [DW-1:0] old,
                                     input bit obad, input bit other_wr_same,
                                     input logic [DW-1:0] owd, input logic [DW-1:0] last);
        res_t r;
        r = '{v: 1'b0, pe: 1'b0, d: last};
        if (acc) begin
            if (wr) begin
                if (mode == M_READ)       r = '{v: 1'b1, pe: obad, d: old};
                else if (mode == M_WRITE) r = '{v: 1'b1, pe: 1'b0, d: wd};
            end else if (other_wr_same && mode == M_WRITE) begin
                r = '{v: 1'b1, pe: 1'b0, d: owd};
            end else begin
                r = '{v: 1'b1, pe: obad, d: old};
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = '0;
            bad_m[a] = 1'b0;
        end
        clear_left = DEPTH;
        exp_coll   = 1'b0;
        for (int p = 0; p < 2*NI; p++) begin
            pipe[p].delete();
            last_d[p] = '0;
            for (int k = 1; k < LAT[p/2]; k++) pipe[p].push_back('0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("rst.busy%0d", i), busy[i], 1);
            check_val($sformatf("rst.coll%0d", i), coll[i], 0);
        end
        for (int p = 0; p < 2*NI; p++) begin
            check_val($sformatf("rst.odata%0d", p), odata[p], 0);
            check_val($sformatf("rst.valid%0d", p), valid[p], 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive(input bit e1, input bit w1, input int a1, input int d1,
                         input bit e2, input bit w2, input int a2, input int d2);
        enable1 = e1; write1 = w1; addr1 = AW'(a1); idata1 = DW'(d1);
        enable2 = e2; write2 = w2; addr2 = AW'(a2); idata2 = DW'(d2);
    endtask

    task automatic drive_random(input bit narrow);
        int amask;
        amask = narrow ? 3 : 15;
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) & amask, $urandom_range(0, 255),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) & amask, $urandom_range(0, 255));
    endtask

    // One clock cycle: predict, advance, compare every output of every instance
    task automatic step();
        bit            bz, a1, a2, w1, w2, same;
        logic [DW-1:0] o1, o2;
        bit            b1, b2;
        res_t          r;
        bz   = (clear_left > 0);
        a1   = enable1 && !bz;
        a2   = enable2 && !bz;
        w1   = a1 && write1;
        w2   = a2 && write2;
        same = (addr1 == addr2);
        o1   = mem_m[addr1];
        o2   = mem_m[addr2];
        b1   = bad_m[addr1];
        b2   = bad_m[addr2];
        for (int i = 0; i < NI; i++) begin
            r = predict(MODE[i], a1, w1, idata1, o1, b1, w2 && same, idata2, last_d[2*i]);
            pipe[2*i].push_back(r);
            last_d[2*i] = r.d;
            r = predict(MODE[i], a2, w2, idata2, o2, b2, w1 && same, idata1, last_d[2*i+1]);
            pipe[2*i+1].push_back(r);
            last_d[2*i+1] = r.d;
        end
        if (w2) begin mem_m[addr2] = idata2; bad_m[addr2] = 1'b0; end
        if (w1) begin mem_m[addr1] = idata1; bad_m[addr1] = 1'b0; end
        exp_coll = a1 && a2 && same && (write1 || write2);
        @(posedge clock);
        #1;
        if (clear_left > 0) clear_left--;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("busy%0d", i), busy[i], (clear_left > 0) ? 1 : 0);
            check_val($sformatf("coll%0d", i), coll[i], exp_coll);
        end
        for (int p = 0; p < 2*NI; p++) begin
            r = pipe[p].pop_front();
            check_val($sformatf("inst%0d.valid%0d", p/2, p%2+1), valid[p], r.v);
            check_val($sformatf("inst%0d.odata%0d", p/2, p%2+1), odata[p], r.d);
`ifdef RAM_PARITY_EN
            check_val($sformatf("inst%0d.perr%0d", p/2, p%2+1), perr[p], r.pe);
`endif
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, a, 0, 1, 0, DEPTH - 1 - a, 0);
            step();
        end
        idle(2);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset();

        // Clear period with user traffic that must be ignored, then read back zeros
        for (int k = 0; k < DEPTH; k++) begin drive_random(0); step(); end
        read_all();

        // Port 1 writes 0xA5 @3, port 2 reads it back
        drive(1, 1, 3, 8'hA5, 0, 0, 0, 0);  step();
        drive(0, 0, 0, 0, 1, 0, 3, 0);      step();
        idle(2);

        // 0x11 @5, then port 1 writes 0x3C @5 while port 2 reads @5
        drive(1, 1, 5, 8'h11, 0, 0, 0, 0);     step();
        drive(1, 1, 5, 8'h3C, 1, 0, 5, 0);     step();
        idle(2);

        // Both ports write @7, then read it back
        drive(1, 1, 7, 8'h01, 1, 1, 7, 8'h02); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);         step();
        drive(1, 0, 7, 0, 1, 0, 7, 0);         step();
        idle(2);

        // Reset 5 cycles into the clear, then traffic during the restarted clear
        do_reset();
        for (int k = 0; k < 5; k++) begin drive_random(0); step(); end
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin drive_random(0); step(); end
        read_all();

        // Random traffic, alternating wide and narrow address ranges
        for (int k = 0; k < 600; k++) begin
            drive_random(k % 3 == 0);
            step();
        end
        idle(2);

        // Reset in the middle of a read stream
        drive(1, 0, 3, 0, 1, 0, 4, 0);
        step();
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin drive_random(1); step(); end
        for (int k = 0; k < 100; k++) begin drive_random(0); step(); end
        idle(2);

`ifdef RAM_PARITY_EN
        drive(1, 1, 9, 8'h5A, 1, 1, 10, 8'h33); step();
        idle(1);
        g_dut[0].u_dut.mem[9][0] = ~g_dut[0].u_dut.mem[9][0];
        g_dut[1].u_dut.mem[9][0] = ~g_dut[1].u_dut.mem[9][0];
        g_dut[2].u_dut.mem[9][0] = ~g_dut[2].u_dut.mem[9][0];
        mem_m[9] = mem_m[9] ^ 8'h01;
        bad_m[9] = 1'b1;
        drive(1, 0, 9, 0, 1, 0, 10, 0); step();
        drive(1, 0, 10, 0, 1, 0, 9, 0); step();
        idle(2);
        drive(1, 1, 9, 8'h77, 0, 0, 0, 0); step();
        drive(1, 0, 9, 0, 0, 0, 0, 0); step();
        idle(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
